sram_2168_ctrl: RTL and testbench
=================================

Name: sram_2168_ctrl

Overview:
- Synchronous initiator for a bank of four 2168 4Kx4 static RAMs, organised as a 4K x 16 word memory.
  - Chips 3,2 form the upper byte lane; chips 1,0 form the lower byte lane.
- Accepts single-word read/write requests from the internal bus over a req/ack handshake.
- Sequences CE_n, WE_n, address and data-bus drive with programmable setup, access and hold cycle counts.
- Sits between the Sun-2 CPU-side bus logic and the on-board SRAM chips (or their simulation models).

Parameters:
- SETUP_CYC, 1, cycles address/CE_n are stable before the access phase (0..15; 0 skips the SETUP state).
- RD_WAIT, 2, read access cycles with CE_n low and WE_n high (1..15).
- WR_WAIT, 2, write pulse width in cycles with WE_n low (1..15).
- HOLD_CYC, 1, cycles address/data are held after the access phase (0..15; 0 skips the HOLD state).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  request; held high until ack
- we  input  1  1=write, 0=read; sampled on accept
- addr  input  12  word address; sampled on accept
- wdata  input  16  write data; sampled on accept
- be  input  2  byte enables {upper, lower}; sampled on accept
- ack  output  1  one-cycle completion pulse
- rdata  output  16  read data; valid when ack is high after a read, held until the next read completes
- busy  output  1  high in every state except IDLE
- sram_a  output  12  address to all four chips
- sram_ce_n  output  1  shared chip enable, active low
- sram_we_n  output  2  per-byte-lane write enable, active low
- sram_d_out  output  16  data driven to the chips
- sram_d_oe  output  1  high = controller drives the data bus
- sram_d_in  input  16  data returned from the chips

Behaviour:
- Reset (asynchronous) puts the block in IDLE with these outputs:
  - sram_ce_n=1, sram_we_n=2'b11, sram_d_oe=0
  - sram_a=0, sram_d_out=0, rdata=0, ack=0, busy=0
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE -> SETUP -> ACCESS -> HOLD -> DONE -> IDLE.
- A 4-bit down-counter times SETUP, ACCESS and HOLD.
- IDLE:
  - If req=1, latch we/addr/wdata/be.
  - Load the counter and move to SETUP, or to ACCESS if SETUP_CYC=0.
- SETUP:
  - sram_a = latched addr, sram_ce_n=0, sram_we_n=11.
  - For a write, sram_d_oe=1 and sram_d_out=wdata.
- ACCESS, read:
  - sram_ce_n=0, sram_we_n=11, sram_d_oe=0.
  - Lasts RD_WAIT cycles.
  - On the clock edge that ends the phase, rdata <= sram_d_in.
- ACCESS, write:
  - sram_ce_n=0, sram_d_oe=1.
  - sram_we_n[i] = ~be[i]. If be=00, the full cycle still runs with no WE_n pulse, and ack is still issued.
  - Lasts WR_WAIT cycles.
- HOLD:
  - sram_we_n=11; address unchanged.
  - Write: sram_ce_n=0 and sram_d_oe=1, so data is held past the WE_n rising edge.
  - Read: sram_ce_n=1, sram_d_oe=0.
  - Lasts HOLD_CYC cycles; skipped if HOLD_CYC=0.
- DONE:
  - ack=1 for exactly one cycle; sram_ce_n=1, sram_d_oe=0.
  - Next state is IDLE.
- Latency, with the accept cycle numbered 0: ack in cycle 1+SETUP_CYC+WAIT+HOLD_CYC. With defaults this is cycle 5.
- A new req is accepted no earlier than the cycle after DONE.
- Back-to-back requests therefore have a minimum period of 2+SETUP_CYC+WAIT+HOLD_CYC cycles.
- Request inputs are ignored while busy=1. Dropping req mid-transaction does not abort it; the cycle completes and ack is issued.
- sram_we_n is never low while sram_ce_n=1 or while sram_d_oe=0.
- Reset asserted mid-transaction:
  - All SRAM controls are forced inactive immediately.
  - No ack is issued; the transaction is lost.
  - rdata is cleared to 0.
- Address wrap: none. Each request is a single word, and 12'hFFF is a valid address.

Decomposition:
- Shared package sun2_sram_pkg holds:
  - the state encoding: IDLE, SETUP, ACCESS, HOLD, DONE
  - SRAM_AW=12, SRAM_DW=16, lane count 2
  - the default cycle constants
- No sub-module. The counter and FSM fit in one module.
- The bench connects four ttl_2168-style chip models to sram_a/sram_ce_n/sram_we_n, with a tristate resolver built from sram_d_out/sram_d_oe/sram_d_in.

Test Plan:
- After reset: all SRAM controls inactive, ack=0, busy=0. Assert reset mid-write (during ACCESS): sram_we_n goes to 11 within the same cycle, no ack follows, and memory at that address is unchanged or fully written, never X.
- Write addr=12'h123 wdata=16'hBEEF be=11 -> WE_n low for exactly 2 cycles; ack at cycle 5. Read 12'h123 -> ack at cycle 5 with rdata=16'hBEEF.
- Byte lanes: preload 12'h040=16'h1234, write wdata=16'hABCD be=01, read back -> 16'h12CD. Then write be=10 with 16'h5600, read back -> 16'h56CD. A write with be=00 changes nothing and still produces ack.
- Boundary address: write 12'hFFF=16'hA5A5 and 12'h000=16'h5A5A, read both back -> values correct, no aliasing.
- Parameters SETUP_CYC=0, HOLD_CYC=0, RD_WAIT=1 -> read ack at cycle 2. Parameters SETUP_CYC=3, HOLD_CYC=2, WR_WAIT=4 -> write ack at cycle 10. A protocol checker flags any WE_n low with CE_n high, or any bus contention.
- Back-to-back: keep req high through 3 writes and then 3 reads with defaults -> ack every 6 cycles; req toggling while busy is ignored.

Source files
------------

// File: rtl/sun2_sram_pkg.sv
// Shared definitions for the 2168 SRAM bank controller: bus geometry,
// default phase timing and the controller state encoding.
package sun2_sram_pkg;

    localparam int SRAM_AW    = 12;
    localparam int SRAM_DW    = 16;
    localparam int SRAM_LANES = 2;

    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_RD_WAIT   = 2;
    localparam int DEF_WR_WAIT   = 2;
    localparam int DEF_HOLD_CYC  = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [SRAM_AW-1:0]    addr;
        logic [SRAM_DW-1:0]    wdata;
        logic [SRAM_LANES-1:0] be;
    } txn_t;

    // A phase of N cycles counts N-1 down to 0; callers never pass 0.
    function automatic logic [3:0] cnt_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_2168_ctrl.sv
// Single-word read/write initiator for a 4K x 16 bank of 2168 SRAMs with
// programmable setup, access and hold phases; every output is registered.
module sram_2168_ctrl
    import sun2_sram_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int RD_WAIT   = DEF_RD_WAIT,
    parameter int WR_WAIT   = DEF_WR_WAIT,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [15:0] wdata,
    input  logic [1:0]  be,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [11:0] sram_a,
    output logic        sram_ce_n,
    output logic [1:0]  sram_we_n,
    output logic [15:0] sram_d_out,
    output logic        sram_d_oe,
    input  logic [15:0] sram_d_in
);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    txn_t        txn, txn_nx;
    logic        accept;

    logic        ack_nx, busy_nx, ce_n_nx, oe_nx;
    logic [1:0]  we_n_nx;
    logic [11:0] a_nx;
    logic [15:0] d_out_nx, rdata_nx;

    assign accept = (state == IDLE) && req;

    // Request fields are captured only on accept and ignored while busy.
    always_comb begin
        txn_nx = txn;
        if (accept) begin
            txn_nx = '{we: we, addr: addr, wdata: wdata, be: be};
        end
    end

    // State, counter and output registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            txn        <= '0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            sram_a     <= '0;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 2'b11;
            sram_d_out <= '0;
            sram_d_oe  <= 1'b0;
            rdata      <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            txn        <= txn_nx;
            ack        <= ack_nx;
            busy       <= busy_nx;
            sram_a     <= a_nx;
            sram_ce_n  <= ce_n_nx;
            sram_we_n  <= we_n_nx;
            sram_d_out <= d_out_nx;
            sram_d_oe  <= oe_nx;
            rdata      <= rdata_nx;
        end
    end

    // Next-state and phase counter.
    // NOTE: defaults at the top of each combinational block keep every path
    // assigned, so no latches are inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (SETUP_CYC != 0) begin
                        state_nx = SETUP;
                        cnt_nx   = cnt_load(SETUP_CYC);
                    end else begin
                        state_nx = ACCESS;
                        cnt_nx   = cnt_load(txn_nx.we ? WR_WAIT : RD_WAIT);
                    end
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_nx = ACCESS;
                    cnt_nx   = cnt_load(txn.we ? WR_WAIT : RD_WAIT);
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    if (HOLD_CYC != 0) begin
                        state_nx = HOLD;
                        cnt_nx   = cnt_load(HOLD_CYC);
                    end else begin
                        state_nx = DONE;
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output values for the state being entered, registered on the same edge.
    always_comb begin
        ack_nx   = 1'b0;
        busy_nx  = (state_nx != IDLE);
        a_nx     = sram_a;
        ce_n_nx  = 1'b1;
        we_n_nx  = 2'b11;
        d_out_nx = sram_d_out;
        oe_nx    = 1'b0;
        case (state_nx)
            SETUP: begin
                a_nx    = txn_nx.addr;
                ce_n_nx = 1'b0;
                if (txn_nx.we) begin
                    oe_nx    = 1'b1;
                    d_out_nx = txn_nx.wdata;
                end
            end
            ACCESS: begin
                a_nx    = txn_nx.addr;
                ce_n_nx = 1'b0;
                if (txn_nx.we) begin
                    oe_nx    = 1'b1;
                    d_out_nx = txn_nx.wdata;
                    we_n_nx  = ~txn_nx.be;
                end
            end
            HOLD: begin
                // Writes keep CE_n and the data bus past the WE_n rising edge.
                if (txn_nx.we) begin
                    ce_n_nx  = 1'b0;
                    oe_nx    = 1'b1;
                    d_out_nx = txn_nx.wdata;
                end
            end
            DONE:    ack_nx = 1'b1;
            default: ;
        endcase

        rdata_nx = rdata;
        if ((state == ACCESS) && (cnt == 4'd0) && !txn.we) begin
            rdata_nx = sram_d_in;
        end
    end

endmodule

// File: tb/tb_sram_2168_ctrl.sv
// Bench for sram_2168_ctrl: default instance on four 2168 chip models,
// plus fast and slow timing instances driven from an address pattern.
module tb_sram_2168_ctrl;
    import sun2_sram_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, we, ack, busy, ce_n, oe;
    logic [11:0] addr [3];
    logic [11:0] a    [3];
    logic [15:0] wdata[3];
    logic [15:0] rdata[3];
    logic [15:0] d_out[3];
    logic [15:0] d_in [3];
    logic [1:0]  be   [3];
    logic [1:0]  we_n [3];

    int n_tests = 0;
    int n_fail  = 0;
    bit cur_rd  = 1'b0;

    always #5 clk = ~clk;

    sram_2168_ctrl dut (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .be(be[0]), .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]),
        .sram_a(a[0]), .sram_ce_n(ce_n[0]), .sram_we_n(we_n[0]),
        .sram_d_out(d_out[0]), .sram_d_oe(oe[0]), .sram_d_in(d_in[0])
    );

    sram_2168_ctrl #(.SETUP_CYC(0), .RD_WAIT(1), .WR_WAIT(2), .HOLD_CYC(0)) dut_fast (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .be(be[1]), .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]),
        .sram_a(a[1]), .sram_ce_n(ce_n[1]), .sram_we_n(we_n[1]),
        .sram_d_out(d_out[1]), .sram_d_oe(oe[1]), .sram_d_in(d_in[1])
    );

    sram_2168_ctrl #(.SETUP_CYC(3), .RD_WAIT(2), .WR_WAIT(4), .HOLD_CYC(2)) dut_slow (
        .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .wdata(wdata[2]), .be(be[2]), .ack(ack[2]), .rdata(rdata[2]), .busy(busy[2]),
        .sram_a(a[2]), .sram_ce_n(ce_n[2]), .sram_we_n(we_n[2]),
        .sram_d_out(d_out[2]), .sram_d_oe(oe[2]), .sram_d_in(d_in[2])
    );

    // Four 2168 chips: chip 2k holds the low nibble and chip 2k+1 the high
    // nibble of byte lane k.
    logic [3:0]  chip_mem [4][4096] = '{default: '{default: 4'h0}};
    logic [15:0] d_bus;

    assign d_bus   = oe[0] ? d_out[0] : 16'h0;
    assign d_in[0] = ce_n[0] ? 16'h0 :
                     {chip_mem[3][a[0]], chip_mem[2][a[0]], chip_mem[1][a[0]], chip_mem[0][a[0]]};

    function automatic logic [15:0] pat(input logic [11:0] x);
        return {x[3:0], x} ^ 16'h3C5A;
    endfunction

    assign d_in[1] = ce_n[1] ? 16'h0 : pat(a[1]);
    assign d_in[2] = ce_n[2] ? 16'h0 : pat(a[2]);

    always @(negedge clk) begin
        if (!ce_n[0] && !we_n[0][0]) begin
            chip_mem[0][a[0]] <= d_bus[3:0];
            chip_mem[1][a[0]] <= d_bus[7:4];
        end
        if (!ce_n[0] && !we_n[0][1]) begin
            chip_mem[2][a[0]] <= d_bus[11:8];
            chip_mem[3][a[0]] <= d_bus[15:12];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Protocol checker: WE_n low only with CE_n low and the bus driven;
    // the controller never drives while the chips are being read.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (we_n[i] != 2'b11 && ce_n[i]) begin
                n_fail++;
                $display("FAIL proto_we_ce[%0d]: we_n=%b ce_n=%b", i, we_n[i], ce_n[i]);
            end
            if (we_n[i] != 2'b11 && !oe[i]) begin
                n_fail++;
                $display("FAIL proto_we_oe[%0d]: we_n=%b oe=%b", i, we_n[i], oe[i]);
            end
        end
        if (oe[0] && cur_rd) begin
            n_fail++;
            $display("FAIL proto_contention: oe=1 during a read");
        end
    end

    // Scoreboard: one entry pushed per issued request, popped at its ack.
    typedef struct {
        int          inst;
        logic        is_rd;
        logic [15:0] data;
    } sb_t;
    sb_t sb[$];
    sb_t sb_e;

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                if (ack[i]) begin
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected_ack: inst %0d got ack, expected none", i);
                    end else begin
                        sb_e = sb.pop_front();
                        check("sb_inst", i, sb_e.inst);
                        if (sb_e.is_rd) check("sb_rdata", rdata[i], sb_e.data);
                    end
                end
            end
        end
    end

    task automatic do_txn(input int i, input logic w, input logic [11:0] ad,
                          input logic [15:0] wd, input logic [1:0] b,
                          input logic [15:0] exp, input int exp_lat, input int exp_low);
        int lat = 0;
        int low = 0;
        bit got = 1'b0;
        @(negedge clk);
        we[i] = w; addr[i] = ad; wdata[i] = wd; be[i] = b; req[i] = 1'b1;
        if (i == 0) cur_rd = !w;
        sb.push_back('{i, !w, exp});
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (we_n[i] != 2'b11) low++;
            if (lat == 1) check("busy_in_txn", busy[i], 1);
            if (ack[i]) got = 1'b1;
        end
        req[i] = 1'b0;
        check("ack_seen", got, 1);
        check("latency", lat, exp_lat);
        check("we_pulse_cycles", low, exp_low);
        @(negedge clk);
        check("ack_one_cycle", ack[i], 0);
        cur_rd = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [11:0] ad;
        logic [15:0] wd;
        logic [1:0]  b;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[13];

    typedef struct {
        logic        w;
        logic [11:0] ad;
        logic [15:0] wd;
    } op_t;
    op_t b2b[6];

    initial begin
        int acks, cyc, last, k, idx;
        logic [15:0] mval;

        vecs[0]  = '{1'b1, 12'h123, 16'hBEEF, 2'b11, 16'h0000};
        vecs[1]  = '{1'b0, 12'h123, 16'h0000, 2'b11, 16'hBEEF};
        vecs[2]  = '{1'b1, 12'h040, 16'h1234, 2'b11, 16'h0000};
        vecs[3]  = '{1'b1, 12'h040, 16'hABCD, 2'b01, 16'h0000};
        vecs[4]  = '{1'b0, 12'h040, 16'h0000, 2'b11, 16'h12CD};
        vecs[5]  = '{1'b1, 12'h040, 16'h5600, 2'b10, 16'h0000};
        vecs[6]  = '{1'b0, 12'h040, 16'h0000, 2'b11, 16'h56CD};
        vecs[7]  = '{1'b1, 12'h040, 16'hFFFF, 2'b00, 16'h0000};
        vecs[8]  = '{1'b0, 12'h040, 16'h0000, 2'b11, 16'h56CD};
        vecs[9]  = '{1'b1, 12'hFFF, 16'hA5A5, 2'b11, 16'h0000};
        vecs[10] = '{1'b1, 12'h000, 16'h5A5A, 2'b11, 16'h0000};
        vecs[11] = '{1'b0, 12'hFFF, 16'h0000, 2'b11, 16'hA5A5};
        vecs[12] = '{1'b0, 12'h000, 16'h0000, 2'b11, 16'h5A5A};

        b2b[0] = '{1'b1, 12'h200, 16'h1111};
        b2b[1] = '{1'b1, 12'h201, 16'h2222};
        b2b[2] = '{1'b1, 12'h202, 16'h3333};
        b2b[3] = '{1'b0, 12'h200, 16'h1111};
        b2b[4] = '{1'b0, 12'h201, 16'h2222};
        b2b[5] = '{1'b0, 12'h202, 16'h3333};

        reset = 1'b1;
        req = '0; we = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wdata[i] = '0; be[i] = 2'b11;
        end
        repeat (2) @(negedge clk);
        check("rst_ce_n", ce_n[0], 1);
        check("rst_we_n", we_n[0], 2'b11);
        check("rst_oe", oe[0], 0);
        check("rst_a", a[0], 0);
        check("rst_d_out", d_out[0], 0);
        check("rst_rdata", rdata[0], 0);
        check("rst_ack", ack[0], 0);
        check("rst_busy", busy[0], 0);
        reset = 1'b0;

        foreach (vecs[n]) begin
            do_txn(0, vecs[n].w, vecs[n].ad, vecs[n].wd, vecs[n].b, vecs[n].exp, 5,
                   (vecs[n].w && vecs[n].b != 2'b00) ? 2 : 0);
        end

        do_txn(1, 1'b0, 12'h0AB, 16'h0000, 2'b11, pat(12'h0AB), 2, 0);
        do_txn(1, 1'b1, 12'h0CD, 16'h0001, 2'b11, 16'h0000, 3, 2);
        do_txn(2, 1'b1, 12'h055, 16'h0009, 2'b11, 16'h0000, 10, 4);
        do_txn(2, 1'b0, 12'hFFF, 16'h0000, 2'b11, pat(12'hFFF), 8, 0);

        // Back-to-back with req held high; req and inputs scrambled while busy.
        @(negedge clk);
        idx = 0; acks = 0; cyc = 0; last = 0; k = 0;
        we[0] = b2b[0].w; addr[0] = b2b[0].ad; wdata[0] = b2b[0].wd; be[0] = 2'b11;
        req[0] = 1'b1; cur_rd = !b2b[0].w;
        sb.push_back('{0, !b2b[0].w, b2b[0].wd});
        while (acks < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++; k++;
            if (k == 2) begin
                req[0] = 1'b0; addr[0] = 12'hEEE; wdata[0] = 16'hDEAD; we[0] = ~we[0];
            end
            if (k == 3) req[0] = 1'b1;
            if (ack[0]) begin
                acks++;
                if (acks == 1) check("b2b_first_latency", cyc, 5);
                else           check("b2b_period", cyc - last, 6);
                last = cyc; k = 0;
                if (acks < 6) begin
                    idx++;
                    we[0] = b2b[idx].w; addr[0] = b2b[idx].ad; wdata[0] = b2b[idx].wd;
                    cur_rd = !b2b[idx].w;
                    sb.push_back('{0, !b2b[idx].w, b2b[idx].wd});
                end else begin
                    req[0] = 1'b0;
                end
            end
        end
        check("b2b_acks", acks, 6);
        @(negedge clk);
        cur_rd = 1'b0;

        // Reset during the write pulse: controls drop at once, no ack follows.
        check("pre_rst_rdata", rdata[0], 16'h3333);
        @(negedge clk);
        we[0] = 1'b1; addr[0] = 12'h300; wdata[0] = 16'h7777; be[0] = 2'b11; req[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_we_low", we_n[0], 2'b00);
        #2 reset = 1'b1;
        #1;
        check("midrst_we_n", we_n[0], 2'b11);
        check("midrst_ce_n", ce_n[0], 1);
        check("midrst_oe", oe[0], 0);
        check("midrst_busy", busy[0], 0);
        check("midrst_rdata", rdata[0], 0);
        req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack[0]) acks++;
        end
        check("midrst_no_ack", acks, 0);
        mval = {chip_mem[3][12'h300], chip_mem[2][12'h300], chip_mem[1][12'h300], chip_mem[0][12'h300]};
        check("midrst_mem_clean", (mval === 16'h0000 || mval === 16'h7777), 1);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
